mem_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-port memory between the instruction-fetch port and the data (load/store) port of the core.
- This is the first step from separate instruction and data memories to a unified memory for the multicycle core.
- One transaction in flight at a time; round-robin on contention.
- Memory side uses a req/ack handshake with variable latency.

---
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one req/ack memory between fetch and data ports; MEM_ARB_TIMEOUT_EN adds an ack timeout
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic own_d, last_d, first, err_q, pick_d, grant, done, timeout;
  logic [DATA_W-1:0] cap;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // count BUSY cycles without ack; zero whenever not BUSY so each grant starts fresh
  always_ff @(posedge clk)
    if (rst || state != BUSY) cnt <= '0;
    else if (!m_ack) cnt <= cnt + 1'b1;
  assign timeout = state == BUSY && !m_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  assign grant  = state == IDLE && (if_req || d_req);
  assign pick_d = d_req && (!if_req || !last_d);
  assign done   = state == BUSY && (m_ack || timeout);
  assign cap    = timeout ? DATA_W'(32'hDEAD_BEEF) : m_we ? '0 : m_rdata;
  assign m_req     = state == BUSY;
  assign if_gnt    = first && !own_d;
  assign d_gnt     = first && own_d;
  assign if_rvalid = state == RESP && !own_d;
  assign d_rvalid  = state == RESP && own_d;
  assign if_err    = if_rvalid && err_q;
  assign d_err     = d_rvalid && err_q;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: IDLE -> BUSY on any request, BUSY -> RESP on ack/abort, RESP lasts one cycle
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (grant ? BUSY : IDLE) :
               state == BUSY ? (done ? RESP : BUSY) : IDLE;
  end
  // request latches, round-robin pointer and per-port response capture
  always_ff @(posedge clk)
    if (rst) begin
      own_d    <= 1'b0;
      last_d   <= 1'b0;
      first    <= 1'b0;
      err_q    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      first <= grant;
      if (grant) begin
        own_d   <= pick_d;
        m_we    <= pick_d && d_we;
        m_addr  <= pick_d ? d_addr : if_addr;
        m_wdata <= pick_d ? d_wdata : '0;
        m_be    <= pick_d ? d_be : '1;
        err_q   <= 1'b0;
        if (if_req && d_req) last_d <= pick_d;
      end
      if (done) begin
        err_q <= timeout;
        if (own_d) d_rdata <= cap;
        else if_rdata <= cap;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with hand-computed expectations
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr = 0, if_rdata;
  logic d_req = 0, d_we = 0, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [3:0] d_be = 0, m_be;
  logic m_req, m_we, m_ack = 0;
  logic [31:0] m_addr, m_wdata, m_rdata = 0;
  int n_vec = 0, n_err = 0;
  logic gd;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(output logic gnt_d);
    int n = 0;
    while (!(if_gnt || d_gnt) && n < 10) begin
      step();
      n++;
    end
    chk("gnt_wait", n < 10, 1);
    gnt_d = d_gnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    step();
    step();
    chk("rst_outs", {m_req, if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_we}, 0);
    chk("rst_data", {if_rdata, d_rdata, m_addr}, 0);
    rst = 0;
    // single fetch, ack one cycle after m_req rises
    if_req = 1; if_addr = 32'h10;
    step();
    chk("f_gnt", {if_gnt, d_gnt, m_req, m_we, m_be}, {4'b1010, 4'hf});
    chk("f_addr", m_addr, 32'h10);
    if_req = 0; if_addr = 0;
    step();
    chk("f_busy2", {if_gnt, m_req, m_addr}, {2'b01, 32'h10});
    m_ack = 1; m_rdata = 32'h0050_0093;
    step();
    m_ack = 0; m_rdata = 0;
    chk("f_resp", {if_rvalid, if_err, d_rvalid, d_gnt, d_err, m_req, if_rdata}, {6'b100000, 32'h0050_0093});
    step();
    chk("f_hold", {if_rvalid, if_rdata}, {1'b0, 32'h0050_0093});
    // load with ack coinciding with the grant pulse
    d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hf;
    step();
    chk("ld_gnt", {d_gnt, if_gnt, m_we, m_addr}, {3'b100, 32'h200});
    d_req = 0; m_ack = 1; m_rdata = 32'h1234_5678;
    step();
    m_ack = 0; m_rdata = 0;
    chk("ld_resp", {d_rvalid, if_rvalid, d_err, d_rdata}, {3'b100, 32'h1234_5678});
    step();
    // store, ack latency 3
    d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
    step();
    chk("st_gnt", {d_gnt, if_gnt}, 2'b10);
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    for (int i = 0; i < 3; i++) begin
      chk("st_fields", {m_req, m_we, m_addr, m_wdata, m_be}, {2'b11, 32'h104, 32'hCAFE_F00D, 4'b0011});
      if (i == 2) begin m_ack = 1; m_rdata = '1; end
      step();
    end
    m_ack = 0; m_rdata = 0;
    chk("st_resp", {d_rvalid, m_req, d_rdata}, {2'b10, 32'h0});
    step();
    chk("st_once", d_rvalid, 0);
    // stray ack while idle
    m_ack = 1;
    step();
    m_ack = 0;
    chk("stray1", {m_req, if_rvalid, d_rvalid, if_gnt, d_gnt}, 0);
    step();
    chk("stray2", {m_req, if_rvalid, d_rvalid, d_rdata}, 0);
    // contention after reset: D, IF, D, IF
    rst = 1;
    step();
    rst = 0; if_req = 1; d_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(gd);
      chk("cont_order", gd, (k % 2 == 0) ? 1 : 0);
      chk("cont_excl", if_gnt && d_gnt, 0);
      m_ack = 1;
      step();
      m_ack = 0;
      chk("cont_pulse", if_gnt | d_gnt, 0);
      step();
    end
    if_req = 0; d_req = 0;
    step();
    // make D the last contention winner, then reset mid-fetch
    if_req = 1; d_req = 1;
    wait_gnt(gd);
    chk("pre_rst_d", gd, 1);
    if_req = 0; d_req = 0; m_ack = 1;
    step();
    m_ack = 0;
    step();
    if_req = 1;
    step();
    chk("mid_gnt", {if_gnt, m_req}, 2'b11);
    if_req = 0;
    step();
    rst = 1; m_ack = 1; m_rdata = 32'h55;
    step();
    rst = 0; m_ack = 0; m_rdata = 0; if_req = 1; d_req = 1;
    chk("mid_rst", {m_req, if_rvalid, d_rvalid, if_gnt, d_gnt}, 0);
    step();
    chk("mid_next_d", {d_gnt, if_gnt, if_rvalid}, 3'b100);
    if_req = 0; d_req = 0; m_ack = 1;
    step();
    m_ack = 0;
    step();
    // memory never acks
    if_req = 1; if_addr = 32'h40;
    step();
    if_req = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_busy", m_req, 1);
      step();
    end
    chk("to_resp", {m_req, if_rvalid, if_err, d_rvalid, if_rdata}, {4'b0110, 32'hDEAD_BEEF});
    m_ack = 1;
    step();
    m_ack = 0;
    chk("to_late", {if_rvalid, if_err, m_req}, 0);
    step();
    chk("to_late2", {if_rvalid, d_rvalid}, 0);
`else
    for (int i = 0; i < 8; i++) begin
      chk("nto_busy", m_req, 1);
      step();
    end
    m_ack = 1; m_rdata = 32'h77;
    step();
    m_ack = 0;
    chk("nto_resp", {if_rvalid, if_err, if_rdata}, {2'b10, 32'h77});
    step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
